// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states, owner
// encoding and the default transaction timeout.
package mem_arbiter_pkg;

    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DW          = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin tie-break: on a tie the requester not served last wins.
module rr_pick2 (
    input  logic       req_if,
    input  logic       req_d,
    input  logic       last_d,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = {req_d, req_if};
        if (req_if && req_d) begin
            gnt_c = last_d ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch and a data master onto one memory port,
// one transaction at a time, with a per-transaction ready timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    state_e           state_q, state_d;
    owner_e           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic             if_done_q, if_done_d, d_done_q, d_done_d;
    logic             err_q, err_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic             mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [DW-1:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]       pick_c;
    logic             busy_timeout_c;

    rr_pick2 u_pick (
        .req_if (if_req),
        .req_d  (d_req),
        .last_d (last_q == OWN_D),
        .gnt_c  (pick_c)
    );

    // Ready in the same cycle as the final count still completes normally.
    assign busy_timeout_c = !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_c[0]) begin
                    state_d     = ST_IF_BUSY;
                    last_d      = OWN_IF;
                    cnt_d       = '0;
                    if_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end else if (pick_c[1]) begin
                    state_d     = ST_D_BUSY;
                    last_d      = OWN_D;
                    cnt_d       = '0;
                    d_gnt_d     = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            ST_IF_BUSY, ST_D_BUSY: begin
                if (mem_ready || busy_timeout_c) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    err_d       = busy_timeout_c;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (state_q == ST_IF_BUSY) begin
                        if_done_d = 1'b1;
                        if (mem_ready) if_rdata_d = mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (mem_ready && !mem_we_q) d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= OWN_IF;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
